mux_sel_scanner: RTL

Sequencer that sits around a 4-to-1 mux: it drives the mux `sel` and captures the mux output `y` back into a 4-bit word. It steps through the enabled channels, waits a programmable settle time per channel, samples `y`, and presents the assembled word with a one-cycle valid strobe. It supports single-shot and continuous scan modes.

---
 rtl/mux_sel_scanner.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner
//
// Sequencer wrapped around an external 4-to-1 mux. It walks `sel` through the
// enabled channels, waits SETTLE_CYCLES clocks on each one, samples the mux
// output `y_in`, and delivers the assembled 4-bit word with a one-cycle strobe.
// Supports single-shot and continuous scanning.
//
// State table:
//   state     | meaning
//   IDLE      | waiting for start; sel holds its last value
//   SETTLE    | sel driven, counting down to the sample edge of current channel
//   DONE_ZERO | empty channel mask; emit an all-zero word for one cycle
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a scan (honoured only in IDLE)
//   mode        0 = single scan, 1 = continuous (latched on accepted start)
//   stop        request end of continuous scanning (effective while busy)
//   ch_en       channel enable mask, bit i = channel i
//   y_in        mux output
//   sel         mux select, registered
//   busy        high while a scan is in progress
//   data_out    assembled word, 0 in disabled channel positions
//   data_valid  one-cycle pulse, data_out updated in the same cycle
//   scan_count  completed-scan counter, wraps silently

module mux_sel_scanner #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             stop,
    input  logic [3:0]       ch_en,
    input  logic             y_in,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [3:0]       data_out,
    output logic             data_valid,
    output logic [CNT_W-1:0] scan_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE    = 2'd1,
        DONE_ZERO = 2'd2
    } state_t;

    // Counter is loaded with SETTLE_CYCLES-1 and the sample happens on the
    // edge where it reads 0, i.e. SETTLE_CYCLES edges after sel changed.
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state, state_d;
    logic [1:0]       sel_d;
    logic [3:0]       cnt, cnt_d;
    logic [3:0]       en_q, en_d;
    logic             mode_q, mode_d;
    logic [3:0]       shadow, shadow_d;
    logic             stop_flag, stop_d;
    logic             busy_d;
    logic [3:0]       data_out_d;
    logic             data_valid_d;
    logic [CNT_W-1:0] scan_count_d;

    logic [3:0]       shadow_new;
    logic [2:0]       nxt;

    function automatic logic [1:0] lowest_ch(input logic [3:0] en);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (en[i]) r = 2'(i);
        end
        return r;
    endfunction

    // {found, index} of the lowest enabled channel strictly above cur.
    function automatic logic [2:0] next_higher(input logic [3:0] en,
                                               input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (en[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 2'd0;
            cnt        <= 4'd0;
            en_q       <= 4'd0;
            mode_q     <= 1'b0;
            shadow     <= 4'd0;
            stop_flag  <= 1'b0;
            busy       <= 1'b0;
            data_out   <= 4'd0;
            data_valid <= 1'b0;
            scan_count <= '0;
        end else begin
            state      <= state_d;
            sel        <= sel_d;
            cnt        <= cnt_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            shadow     <= shadow_d;
            stop_flag  <= stop_d;
            busy       <= busy_d;
            data_out   <= data_out_d;
            data_valid <= data_valid_d;
            scan_count <= scan_count_d;
        end
    end

    always_comb begin
        state_d      = state;
        sel_d        = sel;
        cnt_d        = cnt;
        en_d         = en_q;
        mode_d       = mode_q;
        shadow_d     = shadow;
        stop_d       = stop_flag;
        busy_d       = busy;
        data_out_d   = data_out;
        data_valid_d = 1'b0;
        scan_count_d = scan_count;
        shadow_new   = shadow;
        nxt          = 3'b000;

        if (busy && stop) stop_d = 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    en_d     = ch_en;
                    shadow_d = 4'd0;
                    if (ch_en != 4'd0) begin
                        sel_d   = lowest_ch(ch_en);
                        cnt_d   = RELOAD;
                        busy_d  = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        state_d = DONE_ZERO;
                    end
                end
            end

            SETTLE: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    shadow_new[sel] = y_in;
                    shadow_d        = shadow_new;
                    nxt             = next_higher(en_q, sel);
                    if (nxt[2]) begin
                        sel_d = nxt[1:0];
                        cnt_d = RELOAD;
                    end else begin
                        data_out_d   = shadow_new;
                        data_valid_d = 1'b1;
                        scan_count_d = scan_count + CNT_W'(1);
                        // A stop arriving on the final sample edge still ends
                        // the run after this word.
                        if (!mode_q || stop_flag || stop) begin
                            busy_d  = 1'b0;
                            stop_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            en_d     = ch_en;
                            shadow_d = 4'd0;
                            if (ch_en != 4'd0) begin
                                sel_d = lowest_ch(ch_en);
                                cnt_d = RELOAD;
                            end else begin
                                state_d = DONE_ZERO;
                            end
                        end
                    end
                end
            end

            DONE_ZERO: begin
                data_out_d   = 4'd0;
                data_valid_d = 1'b1;
                scan_count_d = scan_count + CNT_W'(1);
                busy_d       = 1'b0;
                stop_d       = 1'b0;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
